imem_bank_prog: RTL and testbench

Parametrised successor to the 16x16 instruction-memory bank, with configurable width and depth.
- Loads a preload image on the first clock after reset, then runs as a register file: one combinational read port and one random-access write port.
- Adds a streaming programming mode with an auto-incrementing address and a busy/done handshake.
- Sits between the assembler/loader path and the CPU fetch stage, in place of the fixed high/low IMEM halves.

---
 rtl/imem_bank_prog.sv | 123 ++++++++++++
 tb/tb_imem_bank_prog.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_bank_prog.sv
// imem_bank_prog: parametrised instruction memory with boot preload, random write port and streaming programming.
// Optional even-parity storage and checking is enabled by defining IMEM_PARITY_EN.
module imem_bank_prog #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic [DEPTH*WIDTH-1:0] PRELOAD,
    input  logic [AW-1:0]          READ_SELECT,
    output logic [WIDTH-1:0]       IMEM_OUTPUT,
    input  logic                   WRITE_ENABLE,
    input  logic [AW-1:0]          WRITE_SELECT,
    input  logic [WIDTH-1:0]       IMEM_INPUT,
    input  logic                   PROG_START,
    input  logic                   PROG_VALID,
    input  logic [WIDTH-1:0]       PROG_DATA,
    output logic                   PROG_BUSY,
    output logic                   PROG_DONE,
    output logic                   LOADED,
    output logic                   READ_PARITY_ERR
);
    typedef enum logic [1:0] {BOOT, RUN, PROG} state_t;
    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             busy_q, busy_d, done_q, done_d, loaded_q, loaded_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             rd_ok;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        loaded_d = loaded_q;
        we       = 1'b0;
        wa       = WRITE_SELECT;
        wd       = IMEM_INPUT;
        case (state_q)
            BOOT: begin
                state_d  = RUN;
                loaded_d = 1'b1;
            end
            RUN: begin
                we = WRITE_ENABLE && (32'(WRITE_SELECT) < DEPTH);
                if (PROG_START) begin
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                    state_d = PROG;
                end
            end
            PROG: begin
                if (PROG_VALID) begin
                    we = 1'b1;
                    wa = ptr_q;
                    wd = PROG_DATA;
                    if (ptr_q == AW'(DEPTH - 1)) begin
                        ptr_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q  <= BOOT;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            loaded_q <= loaded_d;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (state_q == BOOT) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= PRELOAD[i*WIDTH +: WIDTH];
        end else if (we) begin
            mem_q[wa] <= wd;
        end
    end

    assign rd_ok       = 32'(READ_SELECT) < DEPTH;
    assign IMEM_OUTPUT = rd_ok ? mem_q[READ_SELECT] : '0;
    assign PROG_BUSY   = busy_q;
    assign PROG_DONE   = done_q;
    assign LOADED      = loaded_q;

`ifdef IMEM_PARITY_EN
    // Stored bit makes each entry even parity; a nonzero XOR over data+parity flags corruption.
    logic par_q [DEPTH];
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) par_q[i] <= 1'b0;
        end else if (state_q == BOOT) begin
            for (int i = 0; i < DEPTH; i++) par_q[i] <= ^PRELOAD[i*WIDTH +: WIDTH];
        end else if (we) begin
            par_q[wa] <= ^wd;
        end
    end
    assign READ_PARITY_ERR = rd_ok ? ((^mem_q[READ_SELECT]) ^ par_q[READ_SELECT]) : 1'b0;
`else
    assign READ_PARITY_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_imem_bank_prog.sv
// tb_imem_bank_prog: directed self-checking bench for imem_bank_prog (16-entry and 12-entry instances).
module tb_imem_bank_prog;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] pre;
    logic [191:0] pre12;
    logic [3:0]   rs, ws, rs12, ws12;
    logic [15:0]  wi, pd, wi12, out, out12;
    logic         we, ps, pv, we12;
    logic         busy, done, loaded, perr;
    logic         busy12, done12, loaded12, perr12;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    imem_bank_prog dut (
        .CLOCK(clk), .RESET(rst), .PRELOAD(pre), .READ_SELECT(rs), .IMEM_OUTPUT(out),
        .WRITE_ENABLE(we), .WRITE_SELECT(ws), .IMEM_INPUT(wi), .PROG_START(ps),
        .PROG_VALID(pv), .PROG_DATA(pd), .PROG_BUSY(busy), .PROG_DONE(done),
        .LOADED(loaded), .READ_PARITY_ERR(perr)
    );

    imem_bank_prog #(.WIDTH(16), .DEPTH(12), .AW(4)) d12 (
        .CLOCK(clk), .RESET(rst), .PRELOAD(pre12), .READ_SELECT(rs12), .IMEM_OUTPUT(out12),
        .WRITE_ENABLE(we12), .WRITE_SELECT(ws12), .IMEM_INPUT(wi12), .PROG_START(1'b0),
        .PROG_VALID(1'b0), .PROG_DATA(16'h0), .PROG_BUSY(busy12), .PROG_DONE(done12),
        .LOADED(loaded12), .READ_PARITY_ERR(perr12)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            rs = 4'(i);
            #1;
            n_cmp++;
            if (out !== 16'h0) begin
                n_err++;
                $display("FAIL reset_out sel=%0d got=%h exp=0000", i, out);
            end
        end
        n_cmp++;
        if ({loaded, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags got=%b exp=000", {loaded, busy, done});
        end
        rst = 1'b0;
        rs  = 4'd5;
        tick();
        n_cmp++;
        if (loaded !== 1'b1 || out !== 16'hA005) begin
            n_err++;
            $display("FAIL boot_load loaded=%b out=%h exp loaded=1 out=a005", loaded, out);
        end
        rs12 = 4'd11;
        #1;
        n_cmp++;
        if (loaded12 !== 1'b1 || out12 !== 16'hC00B) begin
            n_err++;
            $display("FAIL boot_load12 loaded=%b out=%h exp loaded=1 out=c00b", loaded12, out12);
        end
    endtask

    task automatic test_write();
        we = 1'b1; ws = 4'd3; wi = 16'h1234; rs = 4'd3;
        we12 = 1'b1; ws12 = 4'd13; wi12 = 16'hFFFF;
        #1;
        n_cmp++;
        if (out !== 16'hA003) begin
            n_err++;
            $display("FAIL write_same_cycle got=%h exp=a003", out);
        end
        tick();
        we = 1'b0; we12 = 1'b0;
        #1;
        n_cmp++;
        if (out !== 16'h1234) begin
            n_err++;
            $display("FAIL write_next_cycle got=%h exp=1234", out);
        end
        for (int i = 0; i < 16; i++) begin
            rs12 = 4'(i);
            #1;
            n_cmp++;
            if (out12 !== ((i < 12) ? 16'hC000 + 16'(i) : 16'h0)) begin
                n_err++;
                $display("FAIL oob_write12 sel=%0d got=%h exp=%h", i, out12,
                         (i < 12) ? 16'hC000 + 16'(i) : 16'h0);
            end
        end
    endtask

    task automatic start_prog();
        ps = 1'b1;
        tick();
        ps = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL prog_start_busy got=%b exp=1", busy);
        end
    endtask

    task automatic test_prog();
        start_prog();
        for (int k = 0; k < 16; k++) begin
            if (k == 8) begin
                pv = 1'b0;
                repeat (2) begin
                    tick();
                    n_cmp++;
                    if (busy !== 1'b1 || done !== 1'b0) begin
                        n_err++;
                        $display("FAIL prog_gap busy=%b done=%b exp busy=1 done=0", busy, done);
                    end
                end
            end
            pv = 1'b1; pd = 16'hB000 + 16'(k);
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL prog_word%0d busy=%b done=%b exp busy=1 done=0", k, busy, done);
            end
            tick();
        end
        pv = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL prog_done_pulse done=%b busy=%b exp done=1 busy=0", done, busy);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL prog_done_width got=%b exp=0", done);
        end
        for (int i = 0; i < 16; i++) begin
            rs = 4'(i);
            #1;
            n_cmp++;
            if (out !== 16'hB000 + 16'(i)) begin
                n_err++;
                $display("FAIL prog_contents sel=%0d got=%h exp=%h", i, out, 16'hB000 + 16'(i));
            end
        end
    endtask

    task automatic test_prog_ignore();
        start_prog();
        for (int k = 0; k < 16; k++) begin
            pv = 1'b1; pd = 16'hD000 + 16'(k);
            we = (k == 2); ws = 4'd0; wi = 16'hFFFF;
            ps = (k == 4);
            tick();
        end
        pv = 1'b0; we = 1'b0; ps = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_done done=%b busy=%b exp done=1 busy=0", done, busy);
        end
        for (int i = 0; i < 16; i += 4) begin
            rs = 4'(i);
            #1;
            n_cmp++;
            if (out !== 16'hD000 + 16'(i)) begin
                n_err++;
                $display("FAIL ignore_contents sel=%0d got=%h exp=%h", i, out, 16'hD000 + 16'(i));
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        start_prog();
        for (int k = 0; k < 7; k++) begin
            pv = 1'b1; pd = 16'hE000 + 16'(k);
            tick();
        end
        pv = 1'b0;
        rst = 1'b1;
        rs = 4'd6;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || loaded !== 1'b0 || out !== 16'h0) begin
            n_err++;
            $display("FAIL async_reset busy=%b loaded=%b out=%h exp 0 0 0000", busy, loaded, out);
        end
        rs = 4'd0;
        #1;
        n_cmp++;
        if (out !== 16'h0) begin
            n_err++;
            $display("FAIL async_reset_e0 got=%h exp=0000", out);
        end
        rst = 1'b0;
        rs = 4'd5;
        tick();
        n_cmp++;
        if (loaded !== 1'b1 || out !== 16'hA005 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reboot loaded=%b out=%h busy=%b exp 1 a005 0", loaded, out, busy);
        end
    endtask

    task automatic test_parity();
`ifdef IMEM_PARITY_EN
        rs = 4'd2;
        dut.par_q[2] = ~dut.par_q[2];
        #1;
        n_cmp++;
        if (perr !== 1'b1) begin
            n_err++;
            $display("FAIL parity_detect got=%b exp=1", perr);
        end
        we = 1'b1; ws = 4'd2; wi = 16'h5557;
        tick();
        we = 1'b0;
        #1;
        n_cmp++;
        if (perr !== 1'b0 || out !== 16'h5557) begin
            n_err++;
            $display("FAIL parity_rewrite err=%b out=%h exp 0 5557", perr, out);
        end
`else
        for (int i = 0; i < 16; i++) begin
            rs = 4'(i);
            #1;
            n_cmp++;
            if (perr !== 1'b0) begin
                n_err++;
                $display("FAIL parity_tied sel=%0d got=%b exp=0", i, perr);
            end
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        we = 1'b0; ws = '0; wi = '0; ps = 1'b0; pv = 1'b0; pd = '0; rs = '0;
        we12 = 1'b0; ws12 = '0; wi12 = '0; rs12 = '0;
        for (int i = 0; i < 16; i++) pre[i*16 +: 16] = 16'hA000 + 16'(i);
        for (int i = 0; i < 12; i++) pre12[i*16 +: 16] = 16'hC000 + 16'(i);
        test_reset();
        test_write();
        test_prog();
        test_prog_ignore();
        test_reset_mid();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
